// File: rtl/strip_id_issuer.sv
// strip_id_issuer: looks up up to three priority strip IDs for a height
// through rom_strip_id. It then offers the valid IDs, highest priority
// first, to the strip allocator over a grant/reject handshake.
module strip_id_issuer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [3:0] req_height,
    output logic       req_ready,
    output logic [3:0] rom_addr,
    input  logic [3:0] rom_id1,
    input  logic [3:0] rom_id2,
    input  logic [3:0] rom_id3,
    output logic       cand_valid,
    output logic [3:0] cand_id,
    input  logic       cand_grant,
    input  logic       cand_reject,
    output logic       done_valid,
    output logic [3:0] done_id,
    output logic       done_fail,
    output logic       busy
);

    localparam int unsigned ID_W       = 4;
    localparam int unsigned SLOT_W     = 2;
    localparam int unsigned MAX_HEIGHT = 9;
    localparam logic [ID_W-1:0]   INVALID_ID = ID_W'(4'hD);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(2);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_OFFER   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [ID_W-1:0]   rom_addr_q,   rom_addr_d;
    logic [ID_W-1:0]   id0_q,        id0_d;
    logic [ID_W-1:0]   id1_q,        id1_d;
    logic [ID_W-1:0]   id2_q,        id2_d;
    logic [SLOT_W-1:0] slot_q,       slot_d;
    logic              cand_valid_q, cand_valid_d;
    logic [ID_W-1:0]   cand_id_q,    cand_id_d;
    logic              done_valid_q, done_valid_d;
    logic [ID_W-1:0]   done_id_q,    done_id_d;
    logic              done_fail_q,  done_fail_d;

    // Shared OFFER decisions: a grant only counts on a valid candidate (and
    // beats a simultaneous reject); an invalid slot always advances.
    logic req_in_range;
    logic grant_hit;
    logic advance;
    logic last_slot;

    assign req_in_range = (req_height <= ID_W'(MAX_HEIGHT));
    assign grant_hit    = cand_valid_q & cand_grant;
    assign advance      = cand_valid_q ? (cand_reject & ~cand_grant) : 1'b1;
    assign last_slot    = (slot_q >= LAST_SLOT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = req_in_range ? ST_LOOKUP : ST_DONE;
                end
            end
            ST_LOOKUP:  state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_OFFER;
            ST_OFFER: begin
                if (grant_hit || (advance && last_slot)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Handshake status decoded from the state register only
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
    end

    // Datapath next values: ROM address, captured IDs, slot, offer and done
    always_comb begin
        logic [ID_W-1:0] next_id;

        rom_addr_d   = rom_addr_q;
        id0_d        = id0_q;
        id1_d        = id1_q;
        id2_d        = id2_q;
        slot_d       = slot_q;
        cand_valid_d = 1'b0;
        cand_id_d    = INVALID_ID;
        done_valid_d = 1'b0;
        done_id_d    = done_id_q;
        done_fail_d  = done_fail_q;
        next_id      = INVALID_ID;

        unique case (slot_q)
            2'd0:    next_id = id1_q;
            2'd1:    next_id = id2_q;
            default: next_id = INVALID_ID;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_in_range) begin
                        rom_addr_d = req_height;
                    end else begin
                        done_valid_d = 1'b1;
                        done_id_d    = INVALID_ID;
                        done_fail_d  = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                id0_d        = rom_id1;
                id1_d        = rom_id2;
                id2_d        = rom_id3;
                slot_d       = '0;
                cand_valid_d = (rom_id1 != INVALID_ID);
                cand_id_d    = rom_id1;
            end
            ST_OFFER: begin
                if (grant_hit) begin
                    done_valid_d = 1'b1;
                    done_id_d    = cand_id_q;
                    done_fail_d  = 1'b0;
                end else if (advance) begin
                    if (last_slot) begin
                        done_valid_d = 1'b1;
                        done_id_d    = INVALID_ID;
                        done_fail_d  = 1'b1;
                    end else begin
                        slot_d       = slot_q + SLOT_W'(1);
                        cand_valid_d = (next_id != INVALID_ID);
                        cand_id_d    = next_id;
                    end
                end else begin
                    cand_valid_d = cand_valid_q;
                    cand_id_d    = cand_id_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q   <= '0;
            id0_q        <= INVALID_ID;
            id1_q        <= INVALID_ID;
            id2_q        <= INVALID_ID;
            slot_q       <= '0;
            cand_valid_q <= 1'b0;
            cand_id_q    <= INVALID_ID;
            done_valid_q <= 1'b0;
            done_id_q    <= INVALID_ID;
            done_fail_q  <= 1'b0;
        end else begin
            rom_addr_q   <= rom_addr_d;
            id0_q        <= id0_d;
            id1_q        <= id1_d;
            id2_q        <= id2_d;
            slot_q       <= slot_d;
            cand_valid_q <= cand_valid_d;
            cand_id_q    <= cand_id_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            done_fail_q  <= done_fail_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign cand_valid = cand_valid_q;
    assign cand_id    = cand_id_q;
    assign done_valid = done_valid_q;
    assign done_id    = done_id_q;
    assign done_fail  = done_fail_q;

endmodule

// File: doc/strip_id_issuer.md
# strip_id_issuer

Consumer side of the strip-ID lookup: accepts a preprocessed height address (0–9), drives the address input of `rom_strip_id`, and captures its three registered priority IDs one clock later. It then offers the valid IDs one at a time, highest priority first, over a grant/reject handshake to the strip allocator. It reports the first granted ID, or a failure if no ID is granted. The block sits between the height-request source and the allocator, with `rom_strip_id` hanging off its `rom_*` ports.

## Interface
- No parameters; all widths are fixed at 4 bits for height and strip-ID codes.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: height request present.
- `req_height` in 4: height address; 0–9 are legal.
- `req_ready` out 1: high only in IDLE.
- `rom_addr` out 4: registered address driven to `rom_strip_id.addr`.
- `rom_id1` / `rom_id2` / `rom_id3` in 4 each: ROM outputs; `rom_id1` has the highest priority.
- `cand_valid` out 1: a candidate strip-ID code is offered.
- `cand_id` out 4: the offered code (raw ROM code: 0 means strip 1, and so on).
- `cand_grant` in 1: the allocator accepts the offered candidate.
- `cand_reject` in 1: the allocator refuses the offered candidate.
- `done_valid` out 1: one-cycle completion pulse.
- `done_id` out 4: the granted code, or 4'hD on failure.
- `done_fail` out 1: no candidate was granted; qualified by `done_valid`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - LOOKUP: the ROM samples `rom_addr`.
  - CAPTURE: the ROM outputs are valid and are latched into `id0`..`id2`.
  - OFFER: candidates are presented; a 2-bit slot pointer runs 0..2.
  - DONE: the completion pulse is issued.
- **IDLE:**
  - `req_valid & req_ready` at a clock edge accepts the request.
  - `req_height` ≤ 9: latch it into `rom_addr` and go to LOOKUP.
  - `req_height` > 9: go directly to DONE with fail; the ROM is not used and `rom_addr` is unchanged.
- **LOOKUP:** always moves to CAPTURE on the next edge.
- **CAPTURE:** on the next edge, latch `rom_id1..3` into `id0..id2`, set slot to 0, and go to OFFER.
- **OFFER, current slot holds 4'hD (invalid):**
  - `cand_valid` is 0.
  - On the next edge the slot advances; from slot 2 the block goes to DONE with fail.
  - Each invalid slot costs exactly one cycle.
- **OFFER, current slot is valid (any code other than 4'hD, including A–C):**
  - `cand_valid` is 1 and `cand_id` = `id[slot]`.
  - `cand_id` is held stable until a response is sampled.
  - `cand_grant` high: go to DONE with `done_id` = `cand_id` and `done_fail` = 0.
  - `cand_reject` high with `cand_grant` low: advance the slot; from slot 2, go to DONE with fail.
  - `cand_grant` and `cand_reject` both high: grant wins.
  - Neither high: hold the state, slot and outputs.
- **DONE:**
  - `done_valid` is 1 for exactly one cycle, then the block returns to IDLE.
  - On fail, `done_id` is 4'hD and `done_fail` is 1.
- **Responses outside OFFER:** `cand_grant` and `cand_reject` are ignored when `cand_valid` is 0 or the state is not OFFER.
- **Requests while busy:** `req_valid` is ignored (not queued) while `busy` is high.
- **Reset (`rst_n` low, at any time, mid-offer included):** immediately forces IDLE and the output values below. Any pending offer is abandoned without a done pulse.
  - `req_ready` = 1, `busy` = 0.
  - `rom_addr` = 0.
  - `cand_valid` = 0, `cand_id` = 4'hD.
  - `done_valid` = 0, `done_id` = 4'hD, `done_fail` = 0.
  - `id0..id2` = 4'hD, slot = 0.
- **Output derivation:**
  - `cand_valid`, `cand_id`, `done_*` and `rom_addr` are registered.
  - `req_ready` and `busy` are decoded from the state register only; they have no combinational path from any input.

## Timing
- Acceptance edge E0: the state becomes LOOKUP and `rom_addr` = height, both visible after E0.
- E1: the ROM registers its outputs.
- E2: the IDs are captured, and `cand_valid` for slot 0 (if valid) is visible after E2.
  - First-offer latency is 2 cycles from acceptance.
  - Each preceding invalid slot adds 1 cycle.
- A grant or final reject sampled at edge En gives `done_valid` high during the cycle after En.
  - `req_ready` rises after En+1.
  - The earliest next acceptance is edge En+2.
- Out-of-range request accepted at E0: `done_valid` is high after E0 and `req_ready` is high after E1.
- Minimum request-to-done time is 3 cycles: allocator grants immediately, slot 0 valid.

## Test plan
1. **Height 4, ROM = 0,1,2, grant on the first offer.**
   - Required: `cand_id` = 0 after E2 and `done_id` = 0.
   - Required: `done_fail` = 0, done pulse one cycle after the grant, `req_ready` back 2 cycles after the grant.
2. **Height 3, ROM = 3,0,1, reject, reject, grant.**
   - Required: `cand_id` sequence 3, 0, 1, with `done_id` = 1.
   - Required: `cand_id` held stable across 4 stall cycles with no response inserted before the first reject.
3. **Height 0, ROM = 9,7,D, reject both.**
   - Required: offers 9 then 7, then one cycle with `cand_valid` = 0.
   - Required: done with `done_fail` = 1 and `done_id` = 4'hD.
4. **Height 12 (out of range).**
   - Required: no `cand_valid`, `rom_addr` unchanged, `done_fail` = 1 one cycle after acceptance.
5. **Height 9, ROM = A,B,C, `cand_grant` and `cand_reject` both high on the first offer.**
   - Required: grant wins and `done_id` = 4'hA.
   - Required: a `req_valid` pulse presented while busy is not accepted.
6. **`rst_n` asserted low mid-OFFER (height 5, offering 7).**
   - Required: outputs go to their reset values immediately, with no `done_valid`.
   - Required: after release, a new request to height 6 behaves as in scenario 1 timing, offering 5.
